gyro_spi_byte_master: RTL and testbench

- SPI byte engine directly beneath the gyro polling FSM.
- Takes one command/data byte per `begin_transmission` request and shifts it out on MOSI, MSB first, in SPI mode 3 (CPOL=1, CPHA=1).
- Shifts in the simultaneous MISO byte and returns it with a one-cycle `end_transmission` pulse.
- Chip select is not driven here; the polling FSM owns it.

---
 rtl/gyro_spi_byte_master_if.sv | 35 +++
 rtl/gyro_spi_byte_master.sv | 112 +++++++++++
 tb/tb_gyro_spi_byte_master.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/gyro_spi_byte_master_if.sv
// rtl/gyro_spi_byte_master_if.sv - byte request handshake and SPI pins of the gyro byte engine
interface gyro_spi_byte_master_if;
    logic       begin_transmission;
    logic [7:0] send_data;
    logic [7:0] recieved_data;
    logic       end_transmission;
    logic       busy;
    logic       sclk;
    logic       mosi;
    logic       miso;

    // master: the polling FSM issuing bytes and the gyro driving miso
    modport master (
        output begin_transmission,
        output send_data,
        output miso,
        input  recieved_data,
        input  end_transmission,
        input  busy,
        input  sclk,
        input  mosi
    );

    // slave: the byte engine itself
    modport slave (
        input  begin_transmission,
        input  send_data,
        input  miso,
        output recieved_data,
        output end_transmission,
        output busy,
        output sclk,
        output mosi
    );
endinterface

// File: rtl/gyro_spi_byte_master.sv
// rtl/gyro_spi_byte_master.sv - mode 3 SPI byte shifter, MSB first, one byte per request
module gyro_spi_byte_master #(
    parameter int CLK_DIV = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    gyro_spi_byte_master_if.slave bus
);
    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t     state_q, state_n;
    logic [7:0] div_cnt_q, div_cnt_n;
    logic [2:0] bit_cnt_q, bit_cnt_n;
    logic [7:0] tx_shift_q, tx_shift_n;
    logic [7:0] rx_shift_q, rx_shift_n;
    logic [7:0] rx_data_q, rx_data_n;
    logic       sclk_q, sclk_n;
    logic       mosi_q, mosi_n;
    logic       end_q, end_n;
    logic       busy_q, busy_n;
    logic       tick;

    assign tick = (div_cnt_q == DIV_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            div_cnt_q  <= 8'd0;
            bit_cnt_q  <= 3'd0;
            tx_shift_q <= 8'd0;
            rx_shift_q <= 8'd0;
            rx_data_q  <= 8'd0;
            sclk_q     <= 1'b1;
            mosi_q     <= 1'b1;
            end_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_n;
            div_cnt_q  <= div_cnt_n;
            bit_cnt_q  <= bit_cnt_n;
            tx_shift_q <= tx_shift_n;
            rx_shift_q <= rx_shift_n;
            rx_data_q  <= rx_data_n;
            sclk_q     <= sclk_n;
            mosi_q     <= mosi_n;
            end_q      <= end_n;
            busy_q     <= busy_n;
        end
    end

    always_comb begin
        state_n    = state_q;
        div_cnt_n  = div_cnt_q;
        bit_cnt_n  = bit_cnt_q;
        tx_shift_n = tx_shift_q;
        rx_shift_n = rx_shift_q;
        rx_data_n  = rx_data_q;
        sclk_n     = sclk_q;
        mosi_n     = mosi_q;
        end_n      = 1'b0;
        busy_n     = busy_q;

        case (state_q)
            IDLE: begin
                sclk_n = 1'b1;
                busy_n = 1'b0;
                if (bus.begin_transmission) begin
                    tx_shift_n = bus.send_data;
                    mosi_n     = bus.send_data[7];
                    div_cnt_n  = 8'd0;
                    bit_cnt_n  = 3'd0;
                    busy_n     = 1'b1;
                    state_n    = XFER;
                end
            end
            XFER: begin
                div_cnt_n = tick ? 8'd0 : div_cnt_q + 8'd1;
                if (tick) begin
                    if (sclk_q) begin
                        // first fall re-presents bit 7 so mosi gets a full half-period of setup
                        sclk_n     = 1'b0;
                        mosi_n     = tx_shift_q[7];
                        tx_shift_n = {tx_shift_q[6:0], 1'b0};
                    end else begin
                        sclk_n     = 1'b1;
                        rx_shift_n = {rx_shift_q[6:0], bus.miso};
                        bit_cnt_n  = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            rx_data_n = {rx_shift_q[6:0], bus.miso};
                            end_n     = 1'b1;
                            busy_n    = 1'b0;
                            mosi_n    = 1'b1;
                            state_n   = IDLE;
                        end
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.sclk             = sclk_q;
    assign bus.mosi             = mosi_q;
    assign bus.recieved_data    = rx_data_q;
    assign bus.end_transmission = end_q;
    assign bus.busy             = busy_q;
endmodule

// File: tb/tb_gyro_spi_byte_master.sv
// tb/tb_gyro_spi_byte_master.sv - directed bench for the gyro SPI byte engine at CLK_DIV 4 and 2
module tb_gyro_spi_byte_master;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gyro_spi_byte_master_if b4 ();
    gyro_spi_byte_master_if b2 ();

    gyro_spi_byte_master #(.CLK_DIV(4)) dut4 (.clk(clk), .rst(rst), .bus(b4.slave));
    gyro_spi_byte_master #(.CLK_DIV(2)) dut2 (.clk(clk), .rst(rst), .bus(b2.slave));

    int n_tests = 0;
    int n_fail  = 0;

    logic       loop4      = 1'b1;
    logic [7:0] slave_byte = 8'h00;
    logic [3:0] nfall      = 4'd0;

    // slave model updates miso half a clock after each sclk fall, bit 7 first
    assign b4.miso = loop4 ? b4.mosi : slave_byte[3'(8 - nfall)];
    assign b2.miso = b2.mosi;

    int         widths[$];
    int         highs[$];
    int         low_len   = 0;
    int         high_len  = 0;
    logic       prev_sclk = 1'b1;
    logic       low_mosi  = 1'b1;
    logic [7:0] mosi_bits = 8'h00;

    always @(negedge clk) begin
        if (prev_sclk && !b4.sclk) begin
            highs.push_back(high_len);
            high_len = 0;
            nfall = nfall + 4'd1;
        end
        if (!prev_sclk && b4.sclk) begin
            widths.push_back(low_len);
            mosi_bits = {mosi_bits[6:0], low_mosi};
            low_len = 0;
        end
        if (b4.sclk) high_len++;
        else begin
            low_len++;
            low_mosi = b4.mosi;
        end
        if (!b4.busy) nfall = 4'd0;
        prev_sclk = b4.sclk;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // call between edges; returns #1 after the accepting edge (cycle T+1)
    task automatic start(input int sel, input logic [7:0] data);
        if (sel == 2) begin
            b2.begin_transmission = 1'b1;
            b2.send_data = data;
        end else begin
            b4.begin_transmission = 1'b1;
            b4.send_data = data;
        end
        @(posedge clk);
        #1;
        b4.begin_transmission = 1'b0;
        b2.begin_transmission = 1'b0;
    endtask

    task automatic wait_end(input int sel, input int n0, output int lat, output int drop);
        int n;
        n = n0;
        drop = 0;
        while (n <= 400) begin
            if ((sel == 2) ? b2.end_transmission : b4.end_transmission) break;
            if (!((sel == 2) ? b2.busy : b4.busy)) drop = 1;
            @(posedge clk);
            #1;
            n++;
        end
        lat = n;
    endtask

    task automatic count_pulses(input int sel, input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if ((sel == 2) ? b2.end_transmission : b4.end_transmission) cnt++;
        end
    endtask

    initial begin
        int lat, drop, cnt, wbase, hbase, bad;
        b4.begin_transmission = 1'b0;
        b4.send_data = 8'h00;
        b2.begin_transmission = 1'b0;
        b2.send_data = 8'h00;

        @(posedge clk);
        #1;
        check_eq("rst_sclk", b4.sclk, 1);
        check_eq("rst_mosi", b4.mosi, 1);
        check_eq("rst_rx", b4.recieved_data, 8'h00);
        check_eq("rst_end", b4.end_transmission, 0);
        check_eq("rst_busy", b4.busy, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // loopback A6
        @(negedge clk);
        wbase = widths.size();
        start(4, 8'hA6);
        check_eq("t1_busy_first", b4.busy, 1);
        wait_end(4, 1, lat, drop);
        check_eq("t1_latency", lat, 65);
        check_eq("t1_busy_held", drop, 0);
        check_eq("t1_rx", b4.recieved_data, 8'hA6);
        @(posedge clk);
        #1;
        check_eq("t1_end_one_cycle", b4.end_transmission, 0);
        check_eq("t1_busy_after", b4.busy, 0);
        check_eq("t1_low_pulses", widths.size() - wbase, 8);
        bad = 0;
        for (int i = wbase; i < widths.size(); i++) if (widths[i] != 4) bad++;
        check_eq("t1_low_width", bad, 0);

        // slave returns 3C while sending E8
        loop4 = 1'b0;
        slave_byte = 8'h3C;
        @(negedge clk);
        start(4, 8'hE8);
        wait_end(4, 1, lat, drop);
        check_eq("t2_latency", lat, 65);
        check_eq("t2_rx", b4.recieved_data, 8'h3C);
        @(posedge clk);
        #1;
        check_eq("t2_mosi_bits", mosi_bits, 8'hE8);
        check_eq("t2_mosi_idle", b4.mosi, 1);
        check_eq("t2_sclk_idle", b4.sclk, 1);
        loop4 = 1'b1;

        // request while busy is ignored, send_data change does not leak in
        @(negedge clk);
        start(4, 8'hC3);
        repeat (19) @(posedge clk);
        #1;
        b4.begin_transmission = 1'b1;
        b4.send_data = 8'h00;
        @(posedge clk);
        #1;
        b4.begin_transmission = 1'b0;
        wait_end(4, 21, lat, drop);
        check_eq("t3_latency", lat, 65);
        check_eq("t3_rx", b4.recieved_data, 8'hC3);
        count_pulses(4, 80, cnt);
        check_eq("t3_extra_pulses", cnt, 0);
        check_eq("t3_rx_held", b4.recieved_data, 8'hC3);

        // back-to-back 20 then 0F
        @(negedge clk);
        start(4, 8'h20);
        wait_end(4, 1, lat, drop);
        check_eq("t4_lat_a", lat, 65);
        check_eq("t4_rx_a", b4.recieved_data, 8'h20);
        hbase = highs.size();
        start(4, 8'h0F);
        wait_end(4, 1, lat, drop);
        check_eq("t4_lat_b", lat, 65);
        check_eq("t4_rx_b", b4.recieved_data, 8'h0F);
        @(posedge clk);
        #1;
        check_eq("t4_mosi_bits_b", mosi_bits, 8'h0F);
        check_eq("t4_gap_high", (highs.size() > hbase) ? highs[hbase] : -1, 5);

        // asynchronous reset mid-byte
        @(negedge clk);
        start(4, 8'hAA);
        repeat (29) @(posedge clk);
        #4;
        rst = 1'b1;
        #1;
        check_eq("t5_sclk", b4.sclk, 1);
        check_eq("t5_mosi", b4.mosi, 1);
        check_eq("t5_busy", b4.busy, 0);
        check_eq("t5_rx", b4.recieved_data, 8'h00);
        check_eq("t5_end", b4.end_transmission, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        count_pulses(4, 80, cnt);
        check_eq("t5_no_pulse", cnt, 0);
        @(negedge clk);
        start(4, 8'h55);
        wait_end(4, 1, lat, drop);
        check_eq("t5_lat_new", lat, 65);
        check_eq("t5_rx_new", b4.recieved_data, 8'h55);

        // CLK_DIV=2 loopback FF then 00
        @(negedge clk);
        start(2, 8'hFF);
        wait_end(2, 1, lat, drop);
        check_eq("t6_lat_ff", lat, 33);
        check_eq("t6_busy_ff", drop, 0);
        check_eq("t6_rx_ff", b2.recieved_data, 8'hFF);
        @(negedge clk);
        start(2, 8'h00);
        wait_end(2, 1, lat, drop);
        check_eq("t6_lat_00", lat, 33);
        check_eq("t6_rx_00", b2.recieved_data, 8'h00);
        count_pulses(2, 40, cnt);
        check_eq("t6_extra_pulses", cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
